// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame state encoding for the PS/2 receiver
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // bit3=w, bit2=s, bit1=d, bit0=a
    localparam logic [31:0] DEFAULT_KEY_CODES = 32'h1D1B231C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchroniser, clock glitch filter and frame FSM with timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       frame_valid_o,
    output logic [7:0] frame_data_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [FW-1:0]          flt_cnt_q;
    logic                   flt_clk_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    frame_state_e           state_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   parity_q;
    logic [TW-1:0]          tmo_q;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // The filtered clock is about to drop this cycle: the sample data is taken now.
    assign fall = flt_clk_q && !clk_s && (flt_cnt_q == FW'(FILTER_LEN - 1));

    // Bring both lines into the clk domain; idle level of the bus is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN matching samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flt_clk_q <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_s != flt_clk_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_clk_q <= clk_s;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end else begin
            flt_cnt_q <= '0;
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; aborts on a stalled clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            frame_valid_o <= 1'b0;
            frame_data_o  <= '0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!dat_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= dat_s;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!dat_s) begin
                            frame_err_o <= 1'b1;
                        end else if (^{shift_q, parity_q} != 1'b1) begin
                            parity_err_o <= 1'b1;
                        end else begin
                            frame_valid_o <= 1'b1;
                            frame_data_o  <= shift_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q     <= IDLE;
                    tmo_q       <= '0;
                    frame_err_o <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keymap_rx.sv
// rtl/ps2_keymap_rx.sv - PS/2 keyboard receiver with make/break/extended decode into per-key state
module ps2_keymap_rx
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = DEFAULT_KEY_CODES,
    parameter int                      SYNC_STAGES    = 2,
    parameter int                      FILTER_LEN     = 4,
    parameter int                      TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PS2_CLK,
    input  logic                PS2_DATA,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                frame_valid,
    output logic [7:0]          frame_data,
    output logic                parity_err,
    output logic                frame_err
);

    logic                brk_q;
    logic                ext_q;
    logic [NUM_KEYS-1:0] key_held_q;
    logic [NUM_KEYS-1:0] key_press_q;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk_i         (clk),
        .rst_i         (rst),
        .ps2_clk_i     (PS2_CLK),
        .ps2_data_i    (PS2_DATA),
        .frame_valid_o (frame_valid),
        .frame_data_o  (frame_data),
        .parity_err_o  (parity_err),
        .frame_err_o   (frame_err)
    );

    assign key_held  = key_held_q;
    assign key_press = key_press_q;

    // Prefix tracking and key table update; any errored frame drops pending prefixes.
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            key_held_q  <= '0;
            key_press_q <= '0;
        end else begin
            key_press_q <= '0;
            if (parity_err || frame_err) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end else if (frame_valid) begin
                if (frame_data == PS2_BREAK) begin
                    brk_q <= 1'b1;
                end else if (frame_data == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (!ext_q) begin
                        for (int i = 0; i < NUM_KEYS; i++) begin
                            if (frame_data == KEY_CODES[i*8 +: 8]) begin
                                if (brk_q) begin
                                    key_held_q[i] <= 1'b0;
                                end else if (!key_held_q[i]) begin
                                    key_held_q[i]  <= 1'b1;
                                    key_press_q[i] <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_keymap_rx.md
Name: ps2_keymap_rx

Overview:
Parametrised PS/2 keyboard receiver and key-state tracker for the game/controller input path. Samples PS2_CLK/PS2_DATA in the system clock domain through a synchroniser and glitch filter, then checks start, parity and stop bits and enforces a frame timeout. It decodes make, break (F0) and extended (E0) sequences against a configurable table of NUM_KEYS scan codes. Outputs per-key held levels and one-cycle press pulses, so several keys can be held at once.

Parameters:
NUM_KEYS, 4, number of tracked keys; key_held/key_press width
KEY_CODES, 32'h1D1B231C, NUM_KEYS*8 packed set-1/2 make codes; byte i maps to bit i (default: bit3=w 1D, bit2=s 1B, bit1=d 23, bit0=a 1C)
SYNC_STAGES, 2, flip-flop stages on PS2_CLK and PS2_DATA (min 2)
FILTER_LEN, 4, consecutive identical synchronised samples required before the filtered PS2_CLK changes
TIMEOUT_CYCLES, 100000, clk cycles without a filtered falling edge that aborts a frame in progress

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
PS2_CLK  in  1  asynchronous PS/2 clock from device
PS2_DATA  in  1  asynchronous PS/2 data from device
key_held  out  NUM_KEYS  level; bit i =1 while key KEY_CODES[i] is down
key_press  out  NUM_KEYS  one-cycle pulse on the released-to-held transition of bit i
frame_valid  out  1  one-cycle pulse; good frame received
frame_data  out  8  last good byte, LSB first as received; stable until next frame_valid
parity_err  out  1  one-cycle pulse; odd-parity failure
frame_err  out  1  one-cycle pulse; bad start/stop bit or timeout

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0, FSM to IDLE, prefix flags cleared, bit counter 0, timeout counter 0, filter output forced to 1 (idle high). Reset mid-frame discards the partial frame. No error pulse.
- Sampling: both lines pass through SYNC_STAGES flops. The filtered clock toggles only after FILTER_LEN equal samples. A falling edge of the filtered clock samples the synchronised data.
- Frame FSM: IDLE -> DATA on a falling edge with data=0 (start bit). A falling edge with data=1 in IDLE is ignored.
- DATA: 8 edges, shift LSB first. Then PARITY: 1 edge. Then STOP: 1 edge, then return to IDLE.
- At STOP: if stop bit=0, pulse frame_err. Else if (XOR of data ^ parity)!=1, pulse parity_err. Else pulse frame_valid and update frame_data. Pulses assert the cycle after the stop edge is detected.
- Timeout: a counter runs in any state except IDLE and clears on each falling edge. Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err and clears the prefix flags.
- Decoder (acts on frame_valid; outputs update the following cycle):
  - byte F0: set brk.
  - byte E0: set ext.
  - any other byte: compared to every KEY_CODES entry only when ext=0. Afterwards brk and ext clear.
  - Make (brk=0) of entry i: if key_held[i]=0, set it and pulse key_press[i]. If already held (typematic repeat), no pulse.
  - Break (brk=1) of entry i: clear key_held[i], no pulse.
  - Unmatched codes and E0-prefixed codes only consume the prefixes.
  - Duplicate entries in KEY_CODES all update together.
- parity_err or frame_err clears brk and ext; key_held is unchanged.
- Total latency: stop-bit edge at the pin to key_held/key_press ≈ SYNC_STAGES+FILTER_LEN+2 cycles.
- key_press is never asserted in a cycle where the corresponding key_held goes 1->0.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0
  - frame state encoding IDLE/DATA/PARITY/STOP (2 bits)
  - default KEY_CODES value
- Sub-module ps2_rx_frame contains the synchroniser, filter, frame FSM and timeout, and outputs frame_valid/frame_data/parity_err/frame_err.
- The top level instantiates ps2_rx_frame and holds the prefix flags plus the NUM_KEYS compare/hold/pulse logic.

Test Plan:
1. Send frame 1D (odd parity=1, stop=1) -> frame_valid pulse with frame_data=8'h1D; next cycle key_held=4'b1000 and key_press=4'b1000 for exactly one cycle.
2. Hold w, then send 23, then 1D again -> key_held=4'b1010; key_press pulses 4'b0010 once; the repeated 1D gives no pulse.
3. Send F0 then 1D -> key_held bit3 clears to 0 with no key_press. Send E0 1C -> no change, and brk/ext are clear afterwards.
4. Send 1C with wrong parity bit -> parity_err pulse, no frame_valid, key_held unchanged. Next good 1C -> key_held bit0=1.
5. Stop PS2_CLK after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE. A following good 1B sets bit2. A 1-cycle PS2_CLK glitch (< FILTER_LEN) produces no sampled bit.
6. Assert rst for 1 cycle mid-frame with keys held -> all outputs 0 the next cycle; the remaining bits of the interrupted frame produce no frame_valid.
